// File: rtl/branch_cond_unit.sv
// Branch condition unit: {N,V,Z} status register, condition-code evaluation and PC-relative target.
// Optional macro STATUS_FWD_EN forwards n_in/v_in/z_in into the EVAL-cycle condition when load_s is high.
`timescale 1ns/1ps
module branch_cond_unit #(
   parameter int PC_W  = 9,
   parameter int OFF_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_s,
   input  logic              n_in,
   input  logic              v_in,
   input  logic              z_in,
   input  logic              br_req,
   output logic              br_ready,
   input  logic [2:0]        br_cond,
   input  logic [PC_W-1:0]   br_pc,
   input  logic [OFF_W-1:0]  br_off,
   output logic              br_valid,
   input  logic              br_ack,
   output logic              br_taken,
   output logic [PC_W-1:0]   br_target,
   output logic              br_illegal,
   output logic [2:0]        status_nvz
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        status_q, status_d;
   logic [2:0]        cond_q, cond_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic              taken_q, taken_d;
   logic              illegal_q, illegal_d;
   logic [PC_W-1:0]   target_q, target_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic [2:0]        flags_s;
   logic [1:0]        verdict_s;

   // Returns {illegal, taken} for a condition code against {N,V,Z}.
   function automatic logic [1:0] eval_cond(input logic [2:0] cond, input logic [2:0] nvz);
      logic n, v, z;
      {n, v, z} = nvz;
      case (cond)
         3'd0:    eval_cond = {1'b0, 1'b1};
         3'd1:    eval_cond = {1'b0, z};
         3'd2:    eval_cond = {1'b0, ~z};
         3'd3:    eval_cond = {1'b0, n ^ v};
         3'd4:    eval_cond = {1'b0, (n ^ v) | z};
         default: eval_cond = {1'b1, 1'b0};
      endcase
   endfunction

   function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
      sext_off = {PC_W{off[OFF_W-1]}};
      sext_off[OFF_W-1:0] = off;
   endfunction

   // Flags seen by the EVAL-cycle condition evaluation.
   always_comb begin
      flags_s = status_q;
`ifdef STATUS_FWD_EN
      if (load_s) begin
         flags_s = {n_in, v_in, z_in};
      end else begin
         flags_s = status_q;
      end
`endif
   end

   assign verdict_s = eval_cond(cond_q, flags_s);

   // Next-state and datapath for the IDLE/EVAL/DONE handshake.
   always_comb begin
      state_d   = state_q;
      cond_d    = cond_q;
      pc_d      = pc_q;
      off_d     = off_q;
      taken_d   = taken_q;
      illegal_d = illegal_q;
      target_d  = target_q;
      if (load_s) begin
         status_d = {n_in, v_in, z_in};
      end else begin
         status_d = status_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (br_req) begin
               cond_d  = br_cond;
               pc_d    = br_pc;
               off_d   = br_off;
               state_d = ST_EVAL;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EVAL: begin
            {illegal_d, taken_d} = verdict_s;
            target_d             = pc_q + sext_off(off_q);
            state_d              = ST_DONE;
         end
         ST_DONE: begin
            if (br_ack) begin
               state_d   = ST_IDLE;
               taken_d   = 1'b0;
               illegal_d = 1'b0;
               target_d  = '0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            taken_d   = 1'b0;
            illegal_d = 1'b0;
            target_d  = '0;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
      valid_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         status_q  <= 3'b000;
         cond_q    <= 3'b000;
         pc_q      <= '0;
         off_q     <= '0;
         taken_q   <= 1'b0;
         illegal_q <= 1'b0;
         target_q  <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         status_q  <= status_d;
         cond_q    <= cond_d;
         pc_q      <= pc_d;
         off_q     <= off_d;
         taken_q   <= taken_d;
         illegal_q <= illegal_d;
         target_q  <= target_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
      end
   end

   assign br_ready   = ready_q;
   assign br_valid   = valid_q;
   assign br_taken   = taken_q;
   assign br_illegal = illegal_q;
   assign br_target  = target_q;
   assign status_nvz = status_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: expectations queued at issue, compared when br_valid rises.
`timescale 1ns/1ps
module tb_branch_cond_unit;
   localparam int PC_W  = 9;
   localparam int OFF_W = 8;

   logic             clk = 1'b0;
   logic             reset, load_s, n_in, v_in, z_in;
   logic             br_req, br_ready, br_valid, br_ack, br_taken, br_illegal;
   logic [2:0]       br_cond, status_nvz;
   logic [PC_W-1:0]  br_pc, br_target;
   logic [OFF_W-1:0] br_off;

   typedef struct packed {
      logic       taken;
      logic       illegal;
      logic [8:0] target;
   } exp_t;

   exp_t       sb_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [2:0] mdl_nvz;

   branch_cond_unit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
      .clk(clk), .reset(reset), .load_s(load_s), .n_in(n_in), .v_in(v_in), .z_in(z_in),
      .br_req(br_req), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc), .br_off(br_off),
      .br_valid(br_valid), .br_ack(br_ack), .br_taken(br_taken), .br_target(br_target),
      .br_illegal(br_illegal), .status_nvz(status_nvz)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] cond, input logic [8:0] pc,
                                  input logic [7:0] off, input logic [2:0] nvz);
      exp_t e;
      logic n, v, z;
      {n, v, z} = nvz;
      e.illegal = 1'b0;
      e.target  = pc + {off[7], off};
      case (cond)
         3'd0:    e.taken = 1'b1;
         3'd1:    e.taken = z;
         3'd2:    e.taken = ~z;
         3'd3:    e.taken = n ^ v;
         3'd4:    e.taken = (n ^ v) | z;
         default: begin e.taken = 1'b0; e.illegal = 1'b1; end
      endcase
      return e;
   endfunction

   task automatic load_flags(input logic n, input logic v, input logic z);
      @(negedge clk);
      load_s = 1'b1; n_in = n; v_in = v; z_in = z;
      mdl_nvz = {n, v, z};
      @(negedge clk);
      load_s = 1'b0;
      check_eq("status", status_nvz, mdl_nvz);
   endtask

   // Returns at the negedge after the accept edge (unit in EVAL).
   task automatic issue(input logic [2:0] cond, input logic [8:0] pc, input logic [7:0] off,
                        input bit push);
      int w = 0;
      while (!br_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check_eq("issue_ready", br_ready, 1);
      br_req = 1'b1; br_cond = cond; br_pc = pc; br_off = off;
      if (push) sb_q.push_back(model(cond, pc, off, mdl_nvz));
      @(negedge clk);
      br_req = 1'b0;
      check_eq("lat_early", br_valid, 0);
      check_eq("ready_busy", br_ready, 0);
   endtask

   task automatic collect(input int hold, input int exp_lat);
      int   n = 0;
      exp_t e;
      while (!br_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check_eq("latency", n, exp_lat);
      check_eq("sb_nonempty", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else e = '0;
      check_eq("taken", br_taken, e.taken);
      check_eq("illegal", br_illegal, e.illegal);
      check_eq("target", br_target, e.target);
      for (int i = 0; i < hold; i++) begin
         br_req = 1'b1;
         @(negedge clk);
         check_eq("hold_valid", br_valid, 1);
         check_eq("hold_taken", br_taken, e.taken);
         check_eq("hold_target", br_target, e.target);
         check_eq("hold_ready", br_ready, 0);
      end
      br_req = 1'b0;
      br_ack = 1'b1;
      @(negedge clk);
      br_ack = 1'b0;
      check_eq("ack_valid", br_valid, 0);
      check_eq("ack_ready", br_ready, 1);
      check_eq("ack_taken", br_taken, 0);
      check_eq("ack_target", br_target, 0);
      check_eq("ack_illegal", br_illegal, 0);
      @(negedge clk);
      check_eq("no_queue", br_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load_s = 1'b0; n_in = 1'b0; v_in = 1'b0; z_in = 1'b0;
      br_req = 1'b0; br_ack = 1'b0; br_cond = 3'd0; br_pc = 9'd0; br_off = 8'd0;
      mdl_nvz = 3'b000;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", br_ready, 1);
      check_eq("rst_valid", br_valid, 0);
      check_eq("rst_status", status_nvz, 3'b000);
      check_eq("rst_target", br_target, 0);
      check_eq("rst_taken", br_taken, 0);
      check_eq("rst_illegal", br_illegal, 0);
      reset = 1'b0;

      load_flags(1'b1, 1'b0, 1'b0);
      issue(3'd3, 9'h010, 8'hFC, 1'b1);
      collect(0, 1);

      load_flags(1'b0, 1'b0, 1'b0);
      issue(3'd1, 9'h020, 8'h05, 1'b1);
      collect(4, 1);

      issue(3'd0, 9'h1FF, 8'h02, 1'b1);
      collect(0, 1);
      issue(3'd0, 9'h000, 8'hFF, 1'b1);
      collect(1, 1);

      @(negedge clk);
      br_ack = 1'b1;
      @(negedge clk);
      br_ack = 1'b0;
      check_eq("idle_ack_ready", br_ready, 1);
      check_eq("idle_ack_valid", br_valid, 0);

      issue(3'd6, 9'h055, 8'h10, 1'b1);
      collect(0, 1);
      load_flags(1'b0, 1'b1, 1'b0);
      issue(3'd4, 9'h100, 8'h80, 1'b1);
      collect(0, 1);

      // Status load while the result is held: taken must not change.
      load_flags(1'b0, 1'b0, 1'b1);
      issue(3'd2, 9'h0A0, 8'h01, 1'b1);
      @(negedge clk);
      load_s = 1'b1; n_in = 1'b1; v_in = 1'b0; z_in = 1'b0;
      mdl_nvz = 3'b100;
      @(negedge clk);
      load_s = 1'b0;
      check_eq("done_status", status_nvz, mdl_nvz);
      collect(1, 0);

      // Status load in the EVAL cycle.
      load_flags(1'b0, 1'b0, 1'b0);
      issue(3'd1, 9'h033, 8'h7F, 1'b0);
`ifdef STATUS_FWD_EN
      sb_q.push_back(model(3'd1, 9'h033, 8'h7F, 3'b001));
`else
      sb_q.push_back(model(3'd1, 9'h033, 8'h7F, 3'b000));
`endif
      load_s = 1'b1; n_in = 1'b0; v_in = 1'b0; z_in = 1'b1;
      mdl_nvz = 3'b001;
      @(negedge clk);
      load_s = 1'b0;
      collect(0, 0);
      check_eq("fwd_status", status_nvz, mdl_nvz);

      // Reset in the EVAL cycle drops the request.
      issue(3'd0, 9'h044, 8'h04, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mdl_nvz = 3'b000;
      check_eq("mid_rst_ready", br_ready, 1);
      check_eq("mid_rst_valid", br_valid, 0);
      check_eq("mid_rst_status", status_nvz, mdl_nvz);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("mid_rst_novalid", br_valid, 0);
      end

      check_eq("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
